// File: rtl/pkt_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_rx_checker
//  Description : Receive-side packet framing checker. The sop beat carries a
//                header (bits [15:0] = payload beat count N, bits [19:16] =
//                source ID). It validates framing, length and source ID, and
//                counts good frames and error cycles with saturating counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters  : DW    - data bus width (>= 20)
//                CNT_W - frame / error counter width
//                ID    - expected 4-bit source ID
//  Ports       : clk, rst_n (sync, active-low)
//                i_vld, i_sop, i_eop, i_data  - input beat stream
//                o_hdr_vld, o_hdr             - captured header + pulse
//                o_busy                       - FSM outside IDLE
//                o_fmt_err, o_len_err, o_id_err, o_data_err - error pulses
//                o_frame_cnt, o_err_cnt       - saturating counters
//  Options     : PKT_RX_PAYLOAD_CHK_EN - when defined, payload beat k must
//                equal k; mismatches pulse o_data_err. Otherwise o_data_err
//                is tied low and no comparator exists.
// ============================================================================
module pkt_rx_checker #(
    parameter int         DW    = 32,
    parameter int         CNT_W = 16,
    parameter logic [3:0] ID    = 4'd7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sop,
    input  logic             i_vld,
    input  logic [DW-1:0]    i_data,
    input  logic             i_eop,
    output logic             o_hdr_vld,
    output logic [DW-1:0]    o_hdr,
    output logic             o_busy,
    output logic             o_fmt_err,
    output logic             o_len_err,
    output logic             o_id_err,
    output logic             o_data_err,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_PAYLOAD = 2'd1;
    localparam logic [1:0]       c_DROP    = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state, w_state_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic             r_bad, w_bad_nxt;
    logic [DW-1:0]    r_hdr;
    logic             r_hdr_vld, r_fmt_err, r_len_err, r_id_err;
    logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

    logic             w_hdr_cap, w_fmt, w_len, w_id, w_data, w_good, w_any;
    logic             w_id_mis, w_data_mis;
    logic [15:0]      w_n;

`ifdef PKT_RX_PAYLOAD_CHK_EN
    logic             r_data_err;
    // Payload beat k is expected to carry k; r_cnt is the index of this beat.
    assign w_data_mis = (i_data != {{(DW-16){1'b0}}, r_cnt});
`else
    assign w_data_mis = 1'b0;
`endif

    assign w_n      = i_data[15:0];
    assign w_id_mis = (i_data[19:16] != ID);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bad_nxt   = r_bad;
        w_hdr_cap   = 1'b0;
        w_fmt       = 1'b0;
        w_len       = 1'b0;
        w_id        = 1'b0;
        w_data      = 1'b0;
        w_good      = 1'b0;
        if (i_vld) begin
            if (i_sop) begin
                // A header is accepted from any state; only interrupting a
                // payload in progress is a format error (DROP aborts silently).
                w_fmt     = (r_state == c_PAYLOAD);
                w_hdr_cap = 1'b1;
                w_cnt_nxt = 16'd0;
                w_id      = w_id_mis;
                w_bad_nxt = w_id_mis;
                if (i_eop) begin
                    w_state_nxt = c_IDLE;
                    if (w_n == 16'd0) begin
                        w_good = !w_id_mis;
                    end else begin
                        w_len = 1'b1;
                    end
                end else if (w_n == 16'd0) begin
                    w_len       = 1'b1;
                    w_state_nxt = c_DROP;
                end else begin
                    w_state_nxt = c_PAYLOAD;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        w_fmt = 1'b1;
                    end
                    c_PAYLOAD: begin
                        if (r_cnt == r_hdr[15:0]) begin
                            // All N payload beats seen; only eop may follow.
                            if (i_eop) begin
                                w_state_nxt = c_IDLE;
                                w_good      = !r_bad;
                            end else begin
                                w_len       = 1'b1;
                                w_state_nxt = c_DROP;
                            end
                        end else begin
                            w_data    = w_data_mis;
                            w_cnt_nxt = r_cnt + 16'd1;
                            if (w_data_mis) begin
                                w_bad_nxt = 1'b1;
                            end
                            if (i_eop) begin
                                w_state_nxt = c_IDLE;
                                if (w_cnt_nxt == r_hdr[15:0]) begin
                                    w_good = !r_bad && !w_data_mis;
                                end else begin
                                    w_len = 1'b1;
                                end
                            end
                        end
                    end
                    c_DROP: begin
                        if (i_eop) begin
                            w_state_nxt = c_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = c_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_any = w_fmt | w_len | w_id | w_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= 16'd0;
            r_bad       <= 1'b0;
            r_hdr       <= '0;
            r_hdr_vld   <= 1'b0;
            r_fmt_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_id_err    <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bad     <= w_bad_nxt;
            r_hdr_vld <= w_hdr_cap;
            r_fmt_err <= w_fmt;
            r_len_err <= w_len;
            r_id_err  <= w_id;
            if (w_hdr_cap) begin
                r_hdr <= i_data;
            end
            if (w_good && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
            if (w_any && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

`ifdef PKT_RX_PAYLOAD_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_err <= 1'b0;
        end else begin
            r_data_err <= w_data;
        end
    end
    assign o_data_err = r_data_err;
`else
    assign o_data_err = 1'b0;
`endif

    assign o_hdr_vld   = r_hdr_vld;
    assign o_hdr       = r_hdr;
    assign o_busy      = (r_state != c_IDLE);
    assign o_fmt_err   = r_fmt_err;
    assign o_len_err   = r_len_err;
    assign o_id_err    = r_id_err;
    assign o_frame_cnt = r_frame_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
